// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit with architectural HI/LO registers.
// Signed and unsigned forms of both operations; operations can be aborted while in flight.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wd,
    input  logic             hi0_lo1_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     dsr_q, dsr_d;
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 bzero_q, bzero_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 div_zero_q, div_zero_d;

    logic                 a_neg_s, b_neg_s;
    logic [WIDTH-1:0]     a_mag_s, b_mag_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [WIDTH:0]       div_diff_s;
    logic [2*WIDTH-1:0]   product_s;
    logic [WIDTH-1:0]     quo_s, rem_s;

    // Operand magnitudes and per-iteration datapath arithmetic.
    always_comb begin
        a_neg_s    = op[0] & a[WIDTH-1];
        b_neg_s    = op[0] & b[WIDTH-1];
        a_mag_s    = a_neg_s ? (-a) : a;
        b_mag_s    = b_neg_s ? (-b) : b;
        // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}.
        mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc_q[0] ? dsr_q : {WIDTH{1'b0}})};
        div_diff_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, dsr_q};
        product_s  = neg_res_q ? (-acc_q) : acc_q;
        quo_s      = neg_res_q ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_s      = neg_rem_q ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state and register-update logic for the FSM and HI/LO.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        dsr_d      = dsr_q;
        a_raw_d    = a_raw_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        bzero_d    = bzero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        case (state_q)
            S_IDLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d   = S_RUN;
                    cnt_d     = {CW{1'b0}};
                    is_div_d  = op[1];
                    neg_res_d = a_neg_s ^ b_neg_s;
                    neg_rem_d = a_neg_s;
                    bzero_d   = (b == {WIDTH{1'b0}});
                    a_raw_d   = a;
                    acc_d     = {{WIDTH{1'b0}}, (op[1] ? a_mag_s : b_mag_s)};
                    dsr_d     = op[1] ? b_mag_s : a_mag_s;
                end else begin
                    if (wr_hi) begin
                        hi_d = wd;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (wr_lo) begin
                        lo_d = wd;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (!is_div_q) begin
                        acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
                    end else if (!div_diff_s[WIDTH]) begin
                        acc_d = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (abort) begin
                    done_d = 1'b0;
                end else begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d       = product_s[2*WIDTH-1:WIDTH];
                        lo_d       = product_s[WIDTH-1:0];
                        div_zero_d = 1'b0;
                    end else if (bzero_q) begin
                        hi_d       = a_raw_q;
                        lo_d       = {WIDTH{1'b1}};
                        div_zero_d = 1'b1;
                    end else begin
                        hi_d       = rem_s;
                        lo_d       = quo_s;
                        div_zero_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and architectural registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= {CW{1'b0}};
            acc_q      <= {(2*WIDTH){1'b0}};
            dsr_q      <= {WIDTH{1'b0}};
            a_raw_q    <= {WIDTH{1'b0}};
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            bzero_q    <= 1'b0;
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            dsr_q      <= dsr_d;
            a_raw_q    <= a_raw_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            bzero_q    <= bzero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign rd_data  = hi0_lo1_sel ? lo_q : hi_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 32-bit instance for the main sequence and an
// 8-bit instance for the narrow divide and mid-operation reset cases.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        sel;
    logic        rst32, start32, abort32, wr_hi32, wr_lo32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, wd32, rd32;
    logic        busy32, done32, dz32;

    logic        rst8, start8, abort8, wr_hi8, wr_lo8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, wd8, rd8;
    logic        busy8, done8, dz8;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst32), .start(start32), .op(op32), .a(a32), .b(b32),
        .abort(abort32), .wr_hi(wr_hi32), .wr_lo(wr_lo32), .wd(wd32),
        .hi0_lo1_sel(sel), .rd_data(rd32), .busy(busy32), .done(done32), .div_zero(dz32)
    );

    muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .start(start8), .op(op8), .a(a8), .b(b8),
        .abort(abort8), .wr_hi(wr_hi8), .wr_lo(wr_lo8), .wd(wd8),
        .hi0_lo1_sel(sel), .rd_data(rd8), .busy(busy8), .done(done8), .div_zero(dz8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_hilo32(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        sel = 1'b0;
        #1 check({tag, "_hi"}, rd32, hi);
        sel = 1'b1;
        #1 check({tag, "_lo"}, rd32, lo);
        sel = 1'b0;
    endtask

    task automatic rd_hilo8(input string tag, input logic [7:0] hi, input logic [7:0] lo);
        sel = 1'b0;
        #1 check({tag, "_hi"}, rd8, hi);
        sel = 1'b1;
        #1 check({tag, "_lo"}, rd8, lo);
        sel = 1'b0;
    endtask

    task automatic run32(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                         input logic dz);
        int lat;
        int bc;
        op32 = op; a32 = a; b32 = b; start32 = 1'b1;
        tick;
        start32 = 1'b0;
        bc  = busy32 ? 1 : 0;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            tick;
            if (done32) begin
                lat = i;
                break;
            end
            if (busy32) bc++;
        end
        check({tag, "_latency"}, lat, 33);
        check({tag, "_busy_cycles"}, bc, 33);
        check({tag, "_busy_in_done"}, busy32, 1'b0);
        rd_hilo32(tag, hi, lo);
        check({tag, "_div_zero"}, dz32, dz);
    endtask

    task automatic run8(input string tag, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] hi, input logic [7:0] lo,
                        input logic dz);
        int lat;
        op8 = op; a8 = a; b8 = b; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            tick;
            if (done8) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, lat, 9);
        rd_hilo8(tag, hi, lo);
        check({tag, "_div_zero"}, dz8, dz);
    endtask

    initial begin
        sel = 1'b0;
        rst32 = 1'b0; start32 = 1'b0; abort32 = 1'b0; wr_hi32 = 1'b0; wr_lo32 = 1'b0;
        op32 = 2'b00; a32 = 32'h0; b32 = 32'h0; wd32 = 32'h0;
        rst8 = 1'b0; start8 = 1'b0; abort8 = 1'b0; wr_hi8 = 1'b0; wr_lo8 = 1'b0;
        op8 = 2'b00; a8 = 8'h0; b8 = 8'h0; wd8 = 8'h0;

        #12;
        rd_hilo32("reset32", 32'h0, 32'h0);
        check("reset32_busy", busy32, 1'b0);
        check("reset32_done", done32, 1'b0);
        check("reset32_dz", dz32, 1'b0);
        check("reset8_busy", busy8, 1'b0);
        tick;
        rst32 = 1'b1;
        rst8  = 1'b1;
        tick;

        // Arithmetic, issued back to back from the done cycle of the previous one.
        run32("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run32("mult_neg",  2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run32("div_m7_2",  2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run32("div_7_m2",  2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        run32("divu_z",    2'b10, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1);
        tick;
        check("done_single_cycle", done32, 1'b0);

        // Abort in the FIX cycle suppresses the writeback.
        op32 = 2'b00; a32 = 32'd2; b32 = 32'd3; start32 = 1'b1;
        tick;
        start32 = 1'b0;
        repeat (32) tick;
        check("fix_abort_busy_before", busy32, 1'b1);
        abort32 = 1'b1;
        tick;
        abort32 = 1'b0;
        check("fix_abort_done", done32, 1'b0);
        check("fix_abort_busy", busy32, 1'b0);
        rd_hilo32("fix_abort", 32'h00000005, 32'hFFFFFFFF);
        check("fix_abort_dz", dz32, 1'b1);

        run32("multu_2x3", 2'b00, 32'd2, 32'd3, 32'h0, 32'h6, 1'b0);
        run32("div_z_neg", 2'b11, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
        run32("div_minneg", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);

        // MTHI/MTLO, including a simultaneous write of both.
        wr_hi32 = 1'b1; wr_lo32 = 1'b1; wd32 = 32'hA5A5A5A5;
        tick;
        wr_hi32 = 1'b0; wr_lo32 = 1'b0;
        rd_hilo32("mt_both", 32'hA5A5A5A5, 32'hA5A5A5A5);
        wr_hi32 = 1'b1; wd32 = 32'h12345678;
        tick;
        wr_hi32 = 1'b0;
        rd_hilo32("mthi", 32'h12345678, 32'hA5A5A5A5);

        // Start with a simultaneous MTLO (dropped), aborted at edge k+10.
        op32 = 2'b00; a32 = 32'd7; b32 = 32'd9; start32 = 1'b1; wr_lo32 = 1'b1; wd32 = 32'hDEADBEEF;
        tick;
        start32 = 1'b0; wr_lo32 = 1'b0;
        check("run_busy", busy32, 1'b1);
        rd_hilo32("old_while_busy", 32'h12345678, 32'hA5A5A5A5);
        repeat (9) tick;
        abort32 = 1'b1;
        tick;
        abort32 = 1'b0;
        check("abort_busy", busy32, 1'b0);
        check("abort_done", done32, 1'b0);
        rd_hilo32("abort_kept", 32'h12345678, 32'hA5A5A5A5);
        run32("after_abort", 2'b00, 32'd3, 32'd4, 32'h0, 32'hC, 1'b0);

        // Abort wins over start in IDLE.
        abort32 = 1'b1; start32 = 1'b1;
        tick;
        abort32 = 1'b0; start32 = 1'b0;
        check("abort_over_start", busy32, 1'b0);

        // Narrow instance.
        run8("divu8", 2'b10, 8'd200, 8'd7, 8'd4, 8'd28, 1'b0);
        run8("divu8_z", 2'b10, 8'd9, 8'd0, 8'd9, 8'hFF, 1'b1);
        op8 = 2'b10; a8 = 8'd100; b8 = 8'd3; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        repeat (4) tick;
        check("midrun8_busy", busy8, 1'b1);
        #2 rst8 = 1'b0;
        #1;
        check("rst8_busy", busy8, 1'b0);
        check("rst8_done", done8, 1'b0);
        check("rst8_dz", dz8, 1'b0);
        rd_hilo8("rst8", 8'h0, 8'h0);
        tick;
        rst8 = 1'b1;
        tick;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
